fifo_wr_sched: RTL and testbench

Round-robin write-port scheduler for the asynchronous FIFO, in the write-clock domain. Up to NUM_REQ requesters share the single FIFO write port. Each requester owns the port for a bounded burst, and the burst ends on its last-word marker, on a beat limit, or after an idle timeout. The scheduler drives the FIFO's write enable and write data and stalls on the FIFO full flag, so that no word is dropped or duplicated.

---
 rtl/fifo_wr_sched.sv | 142 ++++++++++++++
 tb/tb_fifo_wr_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_sched.sv
// Round-robin scheduler sharing one FIFO write port among NUM_REQ requesters, write-clock domain.
// Optional statistics outputs (stall_cnt, burst_done) are enabled by defining FIFO_WR_SCHED_STATS_EN.
module fifo_wr_sched #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                          w_clk,
  input  logic                          presetfull,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_w_data,
`ifdef FIFO_WR_SCHED_STATS_EN
  output logic [15:0]                   stall_cnt,
  output logic                          burst_done,
`endif
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] BEAT_LAST = 8'(MAX_BURST - 1);
  localparam logic [3:0] IDLE_LAST = 4'(IDLE_TIMEOUT - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner, last_owner, winner;
  logic               found;
  logic [7:0]         beat_cnt;
  logic [3:0]         idle_cnt;
  logic               owner_req, owner_last, write_now, burst_end, take_grant;
  logic [DATA_WIDTH-1:0] owner_data;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign owner_req     = req[owner];
  assign owner_last    = req_last[owner];
  assign busy          = (state == BURST);
  assign write_now     = busy && owner_req && !fifo_full;
  assign fifo_write_en = write_now;
  assign fifo_w_data   = owner_data;

  always_comb begin
    ack = '0;
    if (write_now) ack[owner] = 1'b1;
  end

  always_comb begin
    state_next = state;
    burst_end  = 1'b0;
    take_grant = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          take_grant = 1'b1;
          state_next = BURST;
        end
      end
      BURST: begin
        // A full FIFO freezes both counters, so neither end condition can fire while stalled.
        if (write_now && (owner_last || beat_cnt == BEAT_LAST)) begin
          burst_end  = 1'b1;
          state_next = IDLE;
        end else if (!fifo_full && !owner_req && idle_cnt == IDLE_LAST) begin
          burst_end  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or posedge presetfull) begin
    if (presetfull) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge w_clk or posedge presetfull) begin
    if (presetfull) begin
      gnt        <= '0;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
      idle_cnt   <= '0;
    end else if (take_grant) begin
      gnt        <= NUM_REQ'(1) << winner;
      owner      <= winner;
      last_owner <= winner;
      beat_cnt   <= '0;
      idle_cnt   <= '0;
    end else if (busy) begin
      if (burst_end) gnt <= '0;
      if (!fifo_full) begin
        if (owner_req) begin
          idle_cnt <= '0;
          beat_cnt <= beat_cnt + 8'd1;
        end else begin
          idle_cnt <= idle_cnt + 4'd1;
        end
      end
    end
  end

`ifdef FIFO_WR_SCHED_STATS_EN
  always_ff @(posedge w_clk or posedge presetfull) begin
    if (presetfull) begin
      stall_cnt  <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= burst_end;
      if (busy && owner_req && fifo_full && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed self-checking bench for fifo_wr_sched with default parameters (4 requesters, burst 8, timeout 4).
// Statistics checks are included when FIFO_WR_SCHED_STATS_EN is defined.
module tb_fifo_wr_sched;

  logic        w_clk = 1'b0;
  logic        presetfull;
  logic [3:0]  req, req_last, gnt, ack;
  logic [31:0] req_data;
  logic        fifo_full, fifo_write_en, busy;
  logic [7:0]  fifo_w_data;
`ifdef FIFO_WR_SCHED_STATS_EN
  logic [15:0] stall_cnt;
  logic        burst_done;
`endif

  int errors = 0;
  int checks = 0;

  always #5 w_clk = ~w_clk;

  fifo_wr_sched #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(8), .IDLE_TIMEOUT(4)) dut (
    .w_clk(w_clk),
    .presetfull(presetfull),
    .req(req),
    .req_last(req_last),
    .req_data(req_data),
    .fifo_full(fifo_full),
    .gnt(gnt),
    .ack(ack),
    .fifo_write_en(fifo_write_en),
    .fifo_w_data(fifo_w_data),
`ifdef FIFO_WR_SCHED_STATS_EN
    .stall_cnt(stall_cnt),
    .burst_done(burst_done),
`endif
    .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d, input logic f);
    req       = r;
    req_last  = l;
    req_data  = d;
    fifo_full = f;
    #1;
  endtask

  task automatic doReset();
    presetfull = 1'b1;
    req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    step();
    step();
    presetfull = 1'b0;
  endtask

  // Checks a cycle in which the owner's word is being written.
  task automatic checkWrite(input string tag, input logic [3:0] owner_bit, input logic [7:0] data);
    checkOutput({tag, "_we"}, 32'(fifo_write_en), 32'd1);
    checkOutput({tag, "_ack"}, 32'(ack), 32'(owner_bit));
    checkOutput({tag, "_data"}, 32'(fifo_w_data), 32'(data));
  endtask

  initial begin
    presetfull = 1'b1;
    req = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    #2;
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_we", 32'(fifo_write_en), 32'h0);
    checkOutput("rst_ack", 32'(ack), 32'h0);
`ifdef FIFO_WR_SCHED_STATS_EN
    checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    checkOutput("rst_burst_done", 32'(burst_done), 32'h0);
`endif

    // Single packet of three words from requester 0.
    doReset();
    applyStimulus(4'b0001, 4'b0000, 32'hA1, 1'b0);
    checkOutput("pkt_gnt_idle", 32'(gnt), 32'h0);
    checkOutput("pkt_we_idle", 32'(fifo_write_en), 32'h0);
    step();
    applyStimulus(4'b0001, 4'b0000, 32'hA1, 1'b0);
    checkOutput("pkt_gnt", 32'(gnt), 32'h1);
    checkOutput("pkt_busy", 32'(busy), 32'h1);
    checkWrite("pkt_w1", 4'b0001, 8'hA1);
    step();
    applyStimulus(4'b0001, 4'b0000, 32'hA2, 1'b0);
    checkWrite("pkt_w2", 4'b0001, 8'hA2);
    step();
    applyStimulus(4'b0001, 4'b0001, 32'hA3, 1'b0);
    checkWrite("pkt_w3", 4'b0001, 8'hA3);
    step();
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    checkOutput("pkt_gnt_end", 32'(gnt), 32'h0);
    checkOutput("pkt_busy_end", 32'(busy), 32'h0);

    // Rotation: single-word packets from all four requesters.
    doReset();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b1111, 4'b1111, 32'h13121110, 1'b0);
      checkOutput($sformatf("rot%0d_idle_busy", k), 32'(busy), 32'h0);
      checkOutput($sformatf("rot%0d_idle_gnt", k), 32'(gnt), 32'h0);
      step();
      applyStimulus(4'b1111, 4'b1111, 32'h13121110, 1'b0);
      checkOutput($sformatf("rot%0d_gnt", k), 32'(gnt), 32'h1 << (k % 4));
      checkWrite($sformatf("rot%0d", k), 4'(4'b0001 << (k % 4)), 8'(8'h10 + (k % 4)));
      step();
    end
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);

    // Beat limit: requester 0 streams with no last word; requester 1 waits.
    doReset();
    applyStimulus(4'b0011, 4'b0010, 32'h5020, 1'b0);
    step();
    for (int n = 0; n < 8; n++) begin
      applyStimulus(4'b0011, 4'b0010, 32'h5020 + n, 1'b0);
      checkWrite($sformatf("beat_w%0d", n), 4'b0001, 8'(8'h20 + n));
      step();
    end
    applyStimulus(4'b0011, 4'b0010, 32'h5028, 1'b0);
    checkOutput("beat_gnt_end", 32'(gnt), 32'h0);
    checkOutput("beat_busy_end", 32'(busy), 32'h0);
    step();
    applyStimulus(4'b0011, 4'b0010, 32'h5028, 1'b0);
    checkOutput("beat_gnt_r1", 32'(gnt), 32'h2);
    checkWrite("beat_r1", 4'b0010, 8'h50);
    step();
    applyStimulus(4'b0001, 4'b0000, 32'h28, 1'b0);
    checkOutput("beat_gnt_gap", 32'(gnt), 32'h0);
    step();
    applyStimulus(4'b0001, 4'b0000, 32'h28, 1'b0);
    checkOutput("beat_gnt_r0", 32'(gnt), 32'h1);
    checkWrite("beat_w8", 4'b0001, 8'h28);

    // Full stall for three cycles mid-burst; the beat limit must still give 8 words.
    doReset();
    applyStimulus(4'b0001, 4'b0000, 32'h30, 1'b0);
    step();
    for (int n = 0; n < 2; n++) begin
      applyStimulus(4'b0001, 4'b0000, 32'h30 + n, 1'b0);
      checkWrite($sformatf("full_w%0d", n), 4'b0001, 8'(8'h30 + n));
      step();
    end
    for (int s = 0; s < 3; s++) begin
      applyStimulus(4'b0001, 4'b0000, 32'h32, 1'b1);
      checkOutput($sformatf("full_s%0d_we", s), 32'(fifo_write_en), 32'h0);
      checkOutput($sformatf("full_s%0d_ack", s), 32'(ack), 32'h0);
      checkOutput($sformatf("full_s%0d_gnt", s), 32'(gnt), 32'h1);
      step();
    end
    for (int n = 2; n < 8; n++) begin
      applyStimulus(4'b0001, 4'b0000, 32'h30 + n, 1'b0);
      checkWrite($sformatf("full_w%0d", n), 4'b0001, 8'(8'h30 + n));
      step();
    end
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    checkOutput("full_gnt_end", 32'(gnt), 32'h0);
`ifdef FIFO_WR_SCHED_STATS_EN
    checkOutput("full_stall_cnt", 32'(stall_cnt), 32'd3);
    checkOutput("full_burst_done", 32'(burst_done), 32'h1);
    step();
    checkOutput("full_burst_done_off", 32'(burst_done), 32'h0);
`endif

    // Last word offered while full: no write until full drops.
    doReset();
    applyStimulus(4'b0001, 4'b0001, 32'h3F, 1'b1);
    step();
    applyStimulus(4'b0001, 4'b0001, 32'h3F, 1'b1);
    checkOutput("lf_we0", 32'(fifo_write_en), 32'h0);
    checkOutput("lf_busy0", 32'(busy), 32'h1);
    step();
    applyStimulus(4'b0001, 4'b0001, 32'h3F, 1'b1);
    checkOutput("lf_busy1", 32'(busy), 32'h1);
    applyStimulus(4'b0001, 4'b0001, 32'h3F, 1'b0);
    checkWrite("lf_w", 4'b0001, 8'h3F);
    step();
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0);
    checkOutput("lf_gnt_end", 32'(gnt), 32'h0);

    // Idle timeout: a 3-cycle gap keeps the grant, a 4-cycle gap revokes it.
    doReset();
    applyStimulus(4'b0101, 4'b0000, 32'h660040, 1'b0);
    step();
    applyStimulus(4'b0101, 4'b0000, 32'h660040, 1'b0);
    checkWrite("to_w0", 4'b0001, 8'h40);
    step();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0100, 4'b0000, 32'h660041, 1'b0);
      checkOutput($sformatf("to_gap3_%0d_gnt", k), 32'(gnt), 32'h1);
      checkOutput($sformatf("to_gap3_%0d_we", k), 32'(fifo_write_en), 32'h0);
      step();
    end
    applyStimulus(4'b0101, 4'b0000, 32'h660041, 1'b0);
    checkWrite("to_w1", 4'b0001, 8'h41);
    step();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0100, 4'b0000, 32'h660042, 1'b0);
      checkOutput($sformatf("to_gap4_%0d_gnt", k), 32'(gnt), 32'h1);
      step();
    end
    applyStimulus(4'b0100, 4'b0000, 32'h660042, 1'b0);
    checkOutput("to_gnt_revoked", 32'(gnt), 32'h0);
    checkOutput("to_busy_revoked", 32'(busy), 32'h0);
    step();
    applyStimulus(4'b0100, 4'b0000, 32'h660042, 1'b0);
    checkOutput("to_gnt_next", 32'(gnt), 32'h4);
    checkWrite("to_r2", 4'b0100, 8'h66);

    // Asynchronous reset during requester 2's burst.
    doReset();
    applyStimulus(4'b0100, 4'b0000, 32'h770000, 1'b0);
    step();
    applyStimulus(4'b0100, 4'b0000, 32'h770000, 1'b0);
    checkOutput("mr_gnt", 32'(gnt), 32'h4);
    checkWrite("mr_w0", 4'b0100, 8'h77);
    step();
    applyStimulus(4'b0100, 4'b0000, 32'h780000, 1'b0);
    checkOutput("mr_we_before", 32'(fifo_write_en), 32'h1);
    #2;
    presetfull = 1'b1;
    #1;
    checkOutput("mr_gnt_rst", 32'(gnt), 32'h0);
    checkOutput("mr_we_rst", 32'(fifo_write_en), 32'h0);
    checkOutput("mr_ack_rst", 32'(ack), 32'h0);
    checkOutput("mr_busy_rst", 32'(busy), 32'h0);
    step();
    applyStimulus(4'b1111, 4'b1111, 32'h01020304, 1'b0);
    presetfull = 1'b0;
    #1;
    checkOutput("mr_gnt_idle", 32'(gnt), 32'h0);
    step();
    applyStimulus(4'b1111, 4'b1111, 32'h01020304, 1'b0);
    checkOutput("mr_gnt_first", 32'(gnt), 32'h1);
    checkWrite("mr_first", 4'b0001, 8'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
